// File: rtl/recon_icap_feeder_if.sv
// recon_icap_feeder_if: AXI-Stream style bitstream channel from the DMA read engine
interface recon_icap_feeder_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;
  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/recon_icap_feeder.sv
// recon_icap_feeder: buffers one stream beat at a time and writes it to ICAP as 32-bit words
module recon_icap_feeder #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  recon_icap_feeder_if.slave   s_axis,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  input  logic                 cfg_bitswap,
  input  logic                 cfg_start,
  output logic                 icap_csib,
  output logic                 icap_rdwrb,
  output logic [31:0]          icap_i,
  output logic                 status_busy,
  output logic                 status_done,
  output logic                 status_err,
  output logic [1:0]           status_err_code,
  output logic [LEN_WIDTH-1:0] status_byte_count
);
  localparam int NW = DATA_WIDTH / 32;
  localparam int WW = $clog2(NW + 1);
  localparam int PW = $clog2(KEEP_WIDTH + 1);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, FLUSH} state_t;
  state_t state, state_d;
  logic [DATA_WIDTH-1:0] bdata, bdata_d;
  logic [WW-1:0] bn, bn_d, widx, widx_d, n;
  logic [PW-1:0] pop;
  logic [LEN_WIDTH-1:0] len, len_d, cnt_d, cnt_inc;
  logic [31:0] hold, hold_d, raw, word;
  logic [1:0] code_d;
  logic blast, blast_d, swap, swap_d, err_d, done_d, keep_ok, last_w, hit;
  assign n           = WW'(pop >> 2);
  assign keep_ok     = ((s_axis.tkeep & (s_axis.tkeep + KEEP_WIDTH'(1))) == '0) && (pop[1:0] == 2'b00);
  assign raw         = 32'(bdata >> {widx, 5'd0});
  assign last_w      = widx == bn - WW'(1);
  assign cnt_inc     = status_byte_count + LEN_WIDTH'(4);
  assign hit         = cnt_inc == len;
  assign status_busy = state != IDLE;
  assign s_axis.tready = (state == LOAD) || (state == FLUSH);
  assign icap_csib   = state != DRAIN;
  assign icap_rdwrb  = icap_csib;
  assign icap_i      = icap_csib ? hold : word;
  // count enabled bytes of the incoming beat
  always_comb begin
    pop = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) pop = pop + PW'(s_axis.tkeep[i]);
  end
  // byte 4w goes to the top of the ICAP word, optionally bit-reversed per byte
  always_comb begin
    word = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 8; j++)
        word[24 - 8 * i + (swap ? 7 - j : j)] = raw[8 * i + j];
  end
  // job sequencing: next state, counters and status updates
  always_comb begin
    state_d = state;
    bdata_d = bdata;
    bn_d    = bn;
    blast_d = blast;
    widx_d  = widx;
    len_d   = len;
    swap_d  = swap;
    cnt_d   = status_byte_count;
    err_d   = status_err;
    code_d  = status_err_code;
    done_d  = 1'b0;
    hold_d  = hold;
    case (state)
      IDLE: if (cfg_start) begin
        if (cfg_len != '0 && cfg_len[1:0] == 2'b00) begin
          len_d   = cfg_len;
          swap_d  = cfg_bitswap;
          cnt_d   = '0;
          err_d   = 1'b0;
          code_d  = 2'd0;
          state_d = LOAD;
        end else begin
          err_d  = 1'b1;
          code_d = 2'd3;
        end
      end
      LOAD: if (s_axis.tvalid) begin
        bdata_d = s_axis.tdata;
        bn_d    = n;
        blast_d = s_axis.tlast;
        widx_d  = '0;
        if (!keep_ok) begin
          err_d   = 1'b1;
          code_d  = 2'd3;
          state_d = s_axis.tlast ? IDLE : FLUSH;
        end else if (n == '0) begin
          err_d   = s_axis.tlast ? 1'b1 : err_d;
          code_d  = s_axis.tlast ? 2'd1 : code_d;
          state_d = s_axis.tlast ? IDLE : LOAD;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        hold_d = word;
        cnt_d  = cnt_inc;
        widx_d = widx + WW'(1);
        if (hit) begin
          done_d  = last_w && blast;
          err_d   = !(last_w && blast) ? 1'b1 : err_d;
          code_d  = !(last_w && blast) ? 2'd2 : code_d;
          state_d = blast ? IDLE : FLUSH;
        end else if (last_w) begin
          err_d   = blast ? 1'b1 : err_d;
          code_d  = blast ? 2'd1 : code_d;
          state_d = blast ? IDLE : LOAD;
        end
      end
      FLUSH: state_d = (s_axis.tvalid && s_axis.tlast) ? IDLE : FLUSH;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously so a reset aborts the job at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bdata             <= '0;
      bn                <= '0;
      blast             <= 1'b0;
      widx              <= '0;
      len               <= '0;
      swap              <= 1'b0;
      hold              <= '0;
      status_byte_count <= '0;
      status_err        <= 1'b0;
      status_err_code   <= 2'd0;
      status_done       <= 1'b0;
    end else begin
      state             <= state_d;
      bdata             <= bdata_d;
      bn                <= bn_d;
      blast             <= blast_d;
      widx              <= widx_d;
      len               <= len_d;
      swap              <= swap_d;
      hold              <= hold_d;
      status_byte_count <= cnt_d;
      status_err        <= err_d;
      status_err_code   <= code_d;
      status_done       <= done_d;
    end
  end
endmodule

// File: tb/tb_recon_icap_feeder.sv
// tb_recon_icap_feeder: job table plus reset/backpressure sequences, words checked via scoreboard
module tb_recon_icap_feeder;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int LW = 32;
  typedef struct {
    logic [LW-1:0] len;
    bit            swap;
    int            nb;
    logic [63:0]   k0;
    logic [63:0]   k1;
    int            words;
    logic [1:0]    code;
    int            done;
    logic [LW-1:0] cnt;
  } job_t;
  logic clk = 1'b0;
  logic rst_n;
  logic [LW-1:0] cfg_len;
  logic cfg_bitswap, cfg_start;
  logic icap_csib, icap_rdwrb;
  logic [31:0] icap_i;
  logic status_busy, status_done, status_err;
  logic [1:0] status_err_code;
  logic [LW-1:0] status_byte_count;
  int checks = 0;
  int errors = 0;
  int wc = 0;
  int done_cnt = 0;
  logic [31:0] sb[$];
  logic [31:0] seen[$];
  job_t jobs[8];
  recon_icap_feeder_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_if();
  recon_icap_feeder #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_if),
    .cfg_len(cfg_len), .cfg_bitswap(cfg_bitswap), .cfg_start(cfg_start),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_i(icap_i),
    .status_busy(status_busy), .status_done(status_done), .status_err(status_err),
    .status_err_code(status_err_code), .status_byte_count(status_byte_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7 - i];
    return r;
  endfunction
  function automatic logic [31:0] mword(input logic [DW-1:0] d, input int w, input bit sw);
    logic [31:0] r;
    logic [7:0] b;
    for (int i = 0; i < 4; i++) begin
      b = d[8 * (4 * w + i) +: 8];
      r[31 - 8 * i -: 8] = sw ? rev8(b) : b;
    end
    return r;
  endfunction
  function automatic int beat_words(input logic [63:0] k);
    int p = 0;
    bit ok = 1'b1;
    bit gap = 1'b0;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) begin
        if (gap) ok = 1'b0;
        p++;
      end else gap = 1'b1;
    end
    return (ok && p % 4 == 0) ? p / 4 : 0;
  endfunction
  // ICAP monitor: every selected cycle must be a write matching the scoreboard head
  always @(negedge clk) begin
    if (rst_n) begin
      if (status_done) done_cnt++;
      if (!icap_csib) begin
        wc++;
        seen.push_back(icap_i);
        chk("icap_rdwrb", 64'(icap_rdwrb), 64'(0));
        if (sb.size() == 0) chk("unexpected_word_csib", 64'(icap_csib), 64'(1));
        else chk("icap_word", 64'(icap_i), 64'(sb.pop_front()));
      end
    end
  end
  task automatic start(input logic [LW-1:0] len, input bit sw);
    @(negedge clk);
    cfg_len = len;
    cfg_bitswap = sw;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask
  task automatic send_beat(input logic [DW-1:0] d, input logic [63:0] k, input bit last);
    int t = 0;
    @(negedge clk);
    s_if.tdata = d;
    s_if.tkeep = k;
    s_if.tlast = last;
    s_if.tvalid = 1'b1;
    while (!s_if.tready && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("beat_accept", 64'(s_if.tready), 64'(1));
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
  endtask
  task automatic make_beat(output logic [DW-1:0] d, input bit first);
    for (int i = 0; i < DW / 8; i++) d[8 * i +: 8] = 8'($urandom);
    if (first) begin
      d[7:0]   = 8'h01;
      d[39:32] = 8'hA5;
      d[71:64] = 8'h0F;
    end
  endtask
  task automatic run_job(input job_t j, input bit poke);
    logic [DW-1:0] d;
    logic [63:0] k;
    int pushed = 0;
    int t = 0;
    int nw;
    wc = 0;
    done_cnt = 0;
    seen.delete();
    start(j.len, j.swap);
    chk("busy_after_start", 64'(status_busy), 64'(1));
    if (poke) begin
      cfg_len = 6;
      cfg_start = 1'b1;
      @(negedge clk);
      cfg_start = 1'b0;
      cfg_len = j.len;
      chk("start_while_busy_err", 64'(status_err), 64'(0));
    end
    for (int b = 0; b < j.nb; b++) begin
      k = (b == 0) ? j.k0 : j.k1;
      make_beat(d, b == 0);
      nw = beat_words(k);
      for (int w = 0; w < nw && pushed < j.words; w++) begin
        sb.push_back(mword(d, w, j.swap));
        pushed++;
      end
      send_beat(d, k, b == j.nb - 1);
    end
    while (status_busy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("job_end_busy", 64'(status_busy), 64'(0));
    @(negedge clk);
    chk("job_words", 64'(wc), 64'(j.words));
    chk("job_code", 64'(status_err_code), 64'(j.code));
    chk("job_err", 64'(status_err), 64'(j.code != 2'd0));
    chk("job_done_pulses", 64'(done_cnt), 64'(j.done));
    chk("job_byte_count", 64'(status_byte_count), 64'(j.cnt));
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    logic [DW-1:0] d;
    jobs[0] = '{len: 128, swap: 0, nb: 2, k0: 64'hFFFF_FFFF_FFFF_FFFF, k1: 64'hFFFF_FFFF_FFFF_FFFF, words: 32, code: 0, done: 1, cnt: 128};
    jobs[1] = '{len: 64,  swap: 1, nb: 1, k0: 64'hFFFF_FFFF_FFFF_FFFF, k1: 64'h0, words: 16, code: 0, done: 1, cnt: 64};
    jobs[2] = '{len: 64,  swap: 0, nb: 2, k0: 64'hFFFF_FFFF_FFFF_FFFF, k1: 64'hFFFF, words: 16, code: 2, done: 0, cnt: 64};
    jobs[3] = '{len: 100, swap: 0, nb: 1, k0: 64'hFFFF_FFFF_FFFF_FFFF, k1: 64'h0, words: 16, code: 1, done: 0, cnt: 64};
    jobs[4] = '{len: 32,  swap: 0, nb: 2, k0: 64'hFFFF, k1: 64'hFFFF, words: 8, code: 0, done: 1, cnt: 32};
    jobs[5] = '{len: 64,  swap: 0, nb: 2, k0: 64'h7, k1: 64'hFFFF_FFFF_FFFF_FFFF, words: 0, code: 3, done: 0, cnt: 0};
    jobs[6] = '{len: 32,  swap: 1, nb: 2, k0: 64'h0, k1: 64'hFFFF_FFFF, words: 8, code: 0, done: 1, cnt: 32};
    jobs[7] = '{len: 8,   swap: 0, nb: 1, k0: 64'hFFFF_FFFF, k1: 64'h0, words: 2, code: 2, done: 0, cnt: 8};
    rst_n = 1'b0;
    cfg_len = '0;
    cfg_bitswap = 1'b0;
    cfg_start = 1'b0;
    s_if.tdata = '0;
    s_if.tkeep = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_csib", 64'(icap_csib), 64'(1));
    chk("rst_rdwrb", 64'(icap_rdwrb), 64'(1));
    chk("rst_icap_i", 64'(icap_i), 64'(0));
    chk("rst_tready", 64'(s_if.tready), 64'(0));
    chk("rst_busy", 64'(status_busy), 64'(0));
    chk("rst_status", 64'({status_done, status_err, status_err_code}), 64'(0));
    chk("rst_count", 64'(status_byte_count), 64'(0));
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_no_done", 64'(done_cnt), 64'(0));
    foreach (jobs[i]) begin
      run_job(jobs[i], 1'b0);
      if (i == 1) begin
        chk("swap_01", 64'(seen[0][31:24]), 64'(8'h80));
        chk("swap_A5", 64'(seen[1][31:24]), 64'(8'hA5));
        chk("swap_0F", 64'(seen[2][31:24]), 64'(8'hF0));
      end
    end
    start(6, 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tlast = 1'b1;
    chk("badlen_err", 64'(status_err), 64'(1));
    chk("badlen_code", 64'(status_err_code), 64'(3));
    chk("badlen_busy", 64'(status_busy), 64'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("badlen_tready", 64'(s_if.tready), 64'(0));
    end
    s_if.tvalid = 1'b0;
    start(128, 1'b0);
    make_beat(d, 1'b1);
    for (int w = 0; w < 16; w++) sb.push_back(mword(d, w, 1'b0));
    send_beat(d, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("drain_w5_csib", 64'(icap_csib), 64'(0));
    rst_n = 1'b0;
    #1;
    chk("async_rst_csib", 64'(icap_csib), 64'(1));
    chk("async_rst_icap_i", 64'(icap_i), 64'(0));
    chk("async_rst_busy", 64'(status_busy), 64'(0));
    chk("async_rst_tready", 64'(s_if.tready), 64'(0));
    chk("async_rst_count", 64'(status_byte_count), 64'(0));
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    wc = 0;
    done_cnt = 0;
    repeat (6) @(negedge clk);
    chk("post_rst_words", 64'(wc), 64'(0));
    chk("post_rst_done", 64'(done_cnt), 64'(0));
    run_job(jobs[0], 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
